// File: rtl/axis_pkt_pkg.sv
// ============================================================================
// axis_pkt_pkg : shared types and helpers for the AXI-stream packet validator
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package axis_pkt_pkg;

    localparam int STAT_WIDTH = 32;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        DEST  = 3'd1,
        LONG  = 3'd2,
        SHORT = 3'd3,
        CSUM  = 3'd4
    } drop_reason_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pipe_reg.sv
// ============================================================================
// axis_pipe_reg : 1-deep valid/ready register slice, full throughput
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module axis_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_load;

    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_packet_validator.sv
// ============================================================================
// axis_packet_validator : per-packet dest/length/checksum checks, drives tdrop
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module axis_packet_validator
    import axis_pkt_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int MIN_BEATS   = 2,
    parameter int MAX_BEATS   = 64,
    parameter int DEST_LSB    = 0,
    parameter int DEST_WIDTH  = 2,
    parameter int NUM_PORTS   = 4,
    parameter int CHECKSUM_EN = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tdrop,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [STAT_WIDTH-1:0]  stat_drop_dest,
    output logic [STAT_WIDTH-1:0]  stat_drop_long,
    output logic [STAT_WIDTH-1:0]  stat_drop_short,
    output logic [STAT_WIDTH-1:0]  stat_drop_csum
);

    localparam int                 c_CNT_W  = $clog2(MAX_BEATS + 2);
    localparam logic [c_CNT_W-1:0] c_MIN    = c_CNT_W'(MIN_BEATS);
    localparam logic [c_CNT_W-1:0] c_MAX    = c_CNT_W'(MAX_BEATS);
    localparam logic [c_CNT_W-1:0] c_SAT    = c_CNT_W'(MAX_BEATS + 1);
    localparam int                 c_PIPE_W = TDATA_WIDTH + 2 + DEST_WIDTH;

    state_t                  r_state,  w_state_nxt;
    drop_reason_t            r_reason, w_reason;
    logic [c_CNT_W-1:0]      r_cnt,    w_cnt_nxt;
    logic [TDATA_WIDTH-1:0]  r_xor,    w_xor_nxt;
    logic [DEST_WIDTH-1:0]   r_dest,   w_dest;
    logic [DEST_WIDTH-1:0]   w_hdr_dest;
    logic                    w_accept;
    logic [STAT_WIDTH-1:0]   r_stat_dest, r_stat_long, r_stat_short, r_stat_csum;
    logic [c_PIPE_W-1:0]     w_pipe_in, w_pipe_out;

    // Length and checksum are only decidable once the tlast beat is seen
    function automatic drop_reason_t eop_reason(input logic [c_CNT_W-1:0]     len,
                                                input logic [TDATA_WIDTH-1:0] acc);
        if (len < c_MIN)
            return SHORT;
        if ((CHECKSUM_EN != 0) && (acc != '0))
            return CSUM;
        return NONE;
    endfunction

    assign w_accept   = s_axis_tvalid && s_axis_tready;
    assign w_hdr_dest = s_axis_tdata[DEST_LSB +: DEST_WIDTH];

    always_comb begin
        w_reason  = NONE;
        w_cnt_nxt = r_cnt;
        w_xor_nxt = r_xor ^ s_axis_tdata;
        w_dest    = r_dest;
        case (r_state)
            HDR: begin
                w_dest    = w_hdr_dest;
                w_cnt_nxt = c_CNT_W'(1);
                w_xor_nxt = s_axis_tdata;
                if (32'(w_hdr_dest) >= 32'(NUM_PORTS))
                    w_reason = DEST;
                else if (s_axis_tlast)
                    w_reason = eop_reason(w_cnt_nxt, w_xor_nxt);
            end
            BODY: begin
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (w_cnt_nxt > c_MAX)
                    w_reason = LONG;
                else if (s_axis_tlast)
                    w_reason = eop_reason(w_cnt_nxt, w_xor_nxt);
            end
            DISCARD: begin
                w_reason  = r_reason;
                w_cnt_nxt = (r_cnt == c_SAT) ? r_cnt : r_cnt + c_CNT_W'(1);
            end
            default: ;
        endcase
        w_state_nxt = s_axis_tlast          ? HDR     :
                      (w_reason != NONE)    ? DISCARD : BODY;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= HDR;
            r_reason     <= NONE;
            r_cnt        <= '0;
            r_xor        <= '0;
            r_dest       <= '0;
            r_stat_dest  <= '0;
            r_stat_long  <= '0;
            r_stat_short <= '0;
            r_stat_csum  <= '0;
        end else if (w_accept) begin
            r_state  <= w_state_nxt;
            r_reason <= s_axis_tlast ? NONE : w_reason;
            r_cnt    <= w_cnt_nxt;
            r_xor    <= w_xor_nxt;
            r_dest   <= w_dest;
            if (s_axis_tlast) begin
                case (w_reason)
                    DEST:    r_stat_dest  <= sat_inc(r_stat_dest);
                    LONG:    r_stat_long  <= sat_inc(r_stat_long);
                    SHORT:   r_stat_short <= sat_inc(r_stat_short);
                    CSUM:    r_stat_csum  <= sat_inc(r_stat_csum);
                    default: ;
                endcase
            end
        end
    end

    assign w_pipe_in = {s_axis_tdata, s_axis_tlast, (w_reason != NONE), w_dest};

    axis_pipe_reg #(
        .WIDTH (c_PIPE_W)
    ) u_pipe (
        .clk     (clk),
        .resetn  (resetn),
        .i_data  (w_pipe_in),
        .i_valid (s_axis_tvalid),
        .o_ready (s_axis_tready),
        .o_data  (w_pipe_out),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tlast, m_axis_tdrop, m_axis_tdest} = w_pipe_out;

    assign stat_drop_dest  = r_stat_dest;
    assign stat_drop_long  = r_stat_long;
    assign stat_drop_short = r_stat_short;
    assign stat_drop_csum  = r_stat_csum;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_validator.sv
// ============================================================================
// tb_axis_packet_validator : directed packets with hand-computed tdrop/tdest
// Revision 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_packet_validator;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tdrop;
    logic [1:0]  m_axis_tdest;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] stat_drop_dest, stat_drop_long, stat_drop_short, stat_drop_csum;

    int          total = 0;
    int          bad   = 0;
    bit          mon_en  = 1'b0;
    bit          bp_mode = 1'b0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    bit          q_drop[$];
    logic [1:0]  q_dest[$];

    bit          prev_stall;
    logic [31:0] p_data;
    logic [3:0]  p_flags;

    axis_packet_validator #(
        .TDATA_WIDTH (32),
        .MIN_BEATS   (2),
        .MAX_BEATS   (64),
        .DEST_LSB    (0),
        .DEST_WIDTH  (2),
        .NUM_PORTS   (2),
        .CHECKSUM_EN (1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tdrop    (m_axis_tdrop),
        .m_axis_tdest    (m_axis_tdest),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .stat_drop_dest  (stat_drop_dest),
        .stat_drop_long  (stat_drop_long),
        .stat_drop_short (stat_drop_short),
        .stat_drop_csum  (stat_drop_csum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input int d, input int l, input int s, input int c);
        chk({tag, "_dest"},  stat_drop_dest,  d);
        chk({tag, "_long"},  stat_drop_long,  l);
        chk({tag, "_short"}, stat_drop_short, s);
        chk({tag, "_csum"},  stat_drop_csum,  c);
    endtask

    // Holds the beat until accepted; returns at posedge+1 with tvalid low
    task automatic send_beat(input logic [31:0] d, input bit l, input bit drop,
                             input logic [1:0] dest, input bit push);
        bit acc = 1'b0;
        int n   = 0;
        if (push) begin
            q_data.push_back(d);
            q_last.push_back(l);
            q_drop.push_back(drop);
            q_dest.push_back(dest);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc)
            chk("send_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q_data.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", q_data.size(), 0);
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("s_ready_rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);
            if (prev_stall) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data",  m_axis_tdata,  p_data);
                chk("stall_flags", {m_axis_tlast, m_axis_tdrop, m_axis_tdest}, p_flags);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (q_data.size() == 0) begin
                    chk("extra_beat", m_axis_tdata, 32'hDEAD_BEEF);
                end else begin
                    chk("out_data", m_axis_tdata, q_data.pop_front());
                    chk("out_last", m_axis_tlast, q_last.pop_front());
                    chk("out_drop", m_axis_tdrop, q_drop.pop_front());
                    chk("out_dest", m_axis_tdest, q_dest.pop_front());
                end
            end
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            p_data     <= m_axis_tdata;
            p_flags    <= {m_axis_tlast, m_axis_tdrop, m_axis_tdest};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        int          len;
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata",  m_axis_tdata,  0);
        chk("rst_flags",  {m_axis_tlast, m_axis_tdrop, m_axis_tdest}, 0);
        chk_stats("rst", 0, 0, 0, 0);
        mon_en = 1'b1;

        // Good packet, XOR = 1^A5^5A^FE = 0, dest 1; checks 1-cycle latency
        send_beat(32'h0000_0001, 0, 0, 2'd1, 1);
        chk("lat_valid", m_axis_tvalid, 1);
        chk("lat_data",  m_axis_tdata,  32'h0000_0001);
        send_beat(32'h0000_00A5, 0, 0, 2'd1, 1);
        send_beat(32'h0000_005A, 0, 0, 2'd1, 1);
        send_beat(32'h0000_00FE, 1, 0, 2'd1, 1);
        drain();
        chk_stats("good", 0, 0, 0, 0);

        // Bad destination 2 with NUM_PORTS=2, then a 2-beat good packet
        send_beat(32'h0000_0006, 0, 1, 2'd2, 1);
        send_beat(32'h0000_0011, 0, 1, 2'd2, 1);
        send_beat(32'h0000_0017, 1, 1, 2'd2, 1);
        chk_stats("dest", 1, 0, 0, 0);
        send_beat(32'h0000_0001, 0, 0, 2'd1, 1);
        send_beat(32'h0000_0001, 1, 0, 2'd1, 1);
        drain();
        chk_stats("after_dest", 1, 0, 0, 0);

        // Exactly MAX_BEATS beats, data i: XOR of 0..63 is 0
        for (int i = 0; i < 64; i++)
            send_beat(32'(i), i == 63, 0, 2'd0, 1);
        drain();
        chk_stats("max_len", 1, 0, 0, 0);

        // 70 beats: drop from beat 64; XOR of 0..69 is 1 but LONG wins
        for (int i = 0; i < 70; i++)
            send_beat(32'(i), i == 69, i >= 64, 2'd0, 1);
        drain();
        chk_stats("long", 1, 1, 0, 0);

        // Single-beat packet below MIN_BEATS
        send_beat(32'h0000_0000, 1, 1, 2'd0, 1);
        chk_stats("short", 1, 1, 1, 0);

        // 3 beats, XOR 0^2^3 = 1: drop only on tlast
        send_beat(32'h0000_0000, 0, 0, 2'd0, 1);
        send_beat(32'h0000_0002, 0, 0, 2'd0, 1);
        send_beat(32'h0000_0003, 1, 1, 2'd0, 1);
        drain();
        chk_stats("csum", 1, 1, 1, 1);

        // Random output backpressure with back-to-back good packets
        bp_mode = 1'b1;
        for (int p = 0; p < 8; p++) begin
            len = 3 + (p % 3);
            x   = 32'(p % 2);
            send_beat(x, 0, 0, 2'(p % 2), 1);
            for (int i = 1; i < len - 1; i++) begin
                send_beat(32'h100 * 32'(p) + 32'(i), 0, 0, 2'(p % 2), 1);
                x = x ^ (32'h100 * 32'(p) + 32'(i));
            end
            send_beat(x, 1, 0, 2'(p % 2), 1);
        end
        drain();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        chk_stats("bp", 1, 1, 1, 1);

        // Reset after beat 2 of 5; next beat must be parsed as a fresh header
        mon_en = 1'b0;
        send_beat(32'h0000_0000, 0, 0, 2'd0, 0);
        send_beat(32'h0000_0003, 0, 0, 2'd0, 0);
        send_beat(32'h0000_0005, 0, 0, 2'd0, 0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk_stats("mid_rst", 0, 0, 0, 0);
        mon_en = 1'b1;
        send_beat(32'h0000_0001, 0, 0, 2'd1, 1);
        send_beat(32'h0000_0001, 1, 0, 2'd1, 1);
        drain();
        chk_stats("post_rst", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
